// File: rtl/operand_latch_if.sv
// Decode-to-execute operand latch bus: decode request, operand sources,
// pipe-stage producer info, and the registered execute-side outputs.
interface operand_latch_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 16
);
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 16;

  logic              id_valid_i;
  logic              id_ready_o;
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] imm_i;
  logic [IDX_W-1:0]  rs1_idx_i;
  logic [IDX_W-1:0]  rs2_idx_i;
  logic [IDX_W-1:0]  rd_idx_i;
  logic              rs1_using_i;
  logic              rs2_using_i;
  logic              rd_wb_n_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] rs1_rf_data_i;
  logic [DATA_W-1:0] rs2_rf_data_i;
  logic              rs1_fwd_sig_i;
  logic              rs2_fwd_sig_i;
  logic [DATA_W-1:0] rs1_fwd_data_i;
  logic [DATA_W-1:0] rs2_fwd_data_i;
  logic [IDX_W-1:0]  pipe_rd_idx_i;
  logic              pipe_wb_n_i;
  logic              pipe_is_load_i;
  logic              flush_i;
  logic              ex_ready_i;
  logic              ex_valid_o;
  logic [DATA_W-1:0] ex_pc_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [DATA_W-1:0] ex_rs1_data_o;
  logic [DATA_W-1:0] ex_rs2_data_o;
  logic [IDX_W-1:0]  ex_rd_idx_o;
  logic              ex_rd_wb_n_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  // Upstream/environment side: drives decode, operand and execute-ready inputs.
  modport master (
    output id_valid_i, pc_i, imm_i, rs1_idx_i, rs2_idx_i, rd_idx_i,
           rs1_using_i, rs2_using_i, rd_wb_n_i, ctrl_i,
           rs1_rf_data_i, rs2_rf_data_i, rs1_fwd_sig_i, rs2_fwd_sig_i,
           rs1_fwd_data_i, rs2_fwd_data_i, pipe_rd_idx_i, pipe_wb_n_i,
           pipe_is_load_i, flush_i, ex_ready_i,
    input  id_ready_o, ex_valid_o, ex_pc_o, ex_imm_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_rd_idx_o, ex_rd_wb_n_o, ex_ctrl_o, stall_cnt_o
  );

  // Latch side.
  modport slave (
    input  id_valid_i, pc_i, imm_i, rs1_idx_i, rs2_idx_i, rd_idx_i,
           rs1_using_i, rs2_using_i, rd_wb_n_i, ctrl_i,
           rs1_rf_data_i, rs2_rf_data_i, rs1_fwd_sig_i, rs2_fwd_sig_i,
           rs1_fwd_data_i, rs2_fwd_data_i, pipe_rd_idx_i, pipe_wb_n_i,
           pipe_is_load_i, flush_i, ex_ready_i,
    output id_ready_o, ex_valid_o, ex_pc_o, ex_imm_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_rd_idx_o, ex_rd_wb_n_o, ex_ctrl_o, stall_cnt_o
  );
endinterface

// File: rtl/operand_latch.sv
// Decode/execute pipeline register with operand forwarding select,
// load-use hazard stall, flush, and a saturating stall-cycle counter.
module operand_latch #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_latch_if.slave bus
);
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] rs1_q, rs1_d;
  logic [DATA_W-1:0] rs2_q, rs2_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              rd_wb_n_q, rd_wb_n_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              hazard;
  logic              adv;
  logic [DATA_W-1:0] rs1_sel;
  logic [DATA_W-1:0] rs2_sel;

  // Hazard detection, operand select and next-state/next-register values.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_idx_d  = rd_idx_q;
    rd_wb_n_d = rd_wb_n_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;

    hazard = bus.id_valid_i & bus.pipe_is_load_i & ~bus.pipe_wb_n_i
           & (bus.pipe_rd_idx_i != IDX_W'(0))
           & ((bus.rs1_using_i & (bus.rs1_idx_i == bus.pipe_rd_idx_i))
            | (bus.rs2_using_i & (bus.rs2_idx_i == bus.pipe_rd_idx_i)));
    adv     = ~valid_q | bus.ex_ready_i;
    rs1_sel = bus.rs1_fwd_sig_i ? bus.rs1_rf_data_i : bus.rs1_fwd_data_i;
    rs2_sel = bus.rs2_fwd_sig_i ? bus.rs2_rf_data_i : bus.rs2_fwd_data_i;

    // Stall counter runs on every unflushed hazard cycle, independent of adv.
    if (hazard && !bus.flush_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.flush_i) begin
      state_d   = RUN;
      valid_d   = 1'b0;
      rd_wb_n_d = 1'b1;
    end else begin
      case (state_q)
        RUN:     if (adv && hazard) state_d = STALL;
        STALL:   if (!hazard)       state_d = RUN;
        default:                    state_d = RUN;
      endcase
      if (adv) begin
        if (bus.id_valid_i && !hazard) begin
          valid_d   = 1'b1;
          pc_d      = bus.pc_i;
          imm_d     = bus.imm_i;
          rs1_d     = rs1_sel;
          rs2_d     = rs2_sel;
          rd_idx_d  = bus.rd_idx_i;
          rd_wb_n_d = bus.rd_wb_n_i;
          ctrl_d    = bus.ctrl_i;
        end else begin
          valid_d   = 1'b0;
          rd_wb_n_d = 1'b1;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Execute-side pipeline registers and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_idx_q  <= '0;
      rd_wb_n_q <= 1'b1;
      ctrl_q    <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_idx_q  <= rd_idx_d;
      rd_wb_n_q <= rd_wb_n_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.id_ready_o    = bus.flush_i | (adv & ~hazard);
  assign bus.ex_valid_o    = valid_q;
  assign bus.ex_pc_o       = pc_q;
  assign bus.ex_imm_o      = imm_q;
  assign bus.ex_rs1_data_o = rs1_q;
  assign bus.ex_rs2_data_o = rs2_q;
  assign bus.ex_rd_idx_o   = rd_idx_q;
  assign bus.ex_rd_wb_n_o  = rd_wb_n_q;
  assign bus.ex_ctrl_o     = ctrl_q;
  assign bus.stall_cnt_o   = cnt_q;
endmodule

// File: doc/operand_latch.md
OPERAND_LATCH -- requirements
Module: operand_latch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning operand/PC/immediate width.
REQ-002 The block SHALL have parameter CTRL_W, default 16, meaning opaque execute-control bundle width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 id_valid_i  input  1  decode holds a valid instruction.
REQ-007 id_ready_o  output  1  instruction accepted this cycle when id_valid_i=1.
REQ-008 pc_i, imm_i  input  DATA_W each  instruction PC and immediate.
REQ-009 rs1_idx_i, rs2_idx_i, rd_idx_i  input  5 each  register indices.
REQ-010 rs1_using_i, rs2_using_i  input  1 each  source register read by this instruction.
REQ-011 rd_wb_n_i  input  1  active-low destination write enable.
REQ-012 ctrl_i  input  CTRL_W  execute control bundle.
REQ-013 rs1_rf_data_i, rs2_rf_data_i  input  DATA_W each  register-file read data.
REQ-014 rs1_fwd_sig_i, rs2_fwd_sig_i  input  1 each  active-low: 0 selects forwarded data.
REQ-015 rs1_fwd_data_i, rs2_fwd_data_i  input  DATA_W each  forwarded data.
REQ-016 pipe_rd_idx_i  input  5  destination index of pipe-stage producer.
REQ-017 pipe_wb_n_i  input  1  active-low write enable of pipe-stage producer.
REQ-018 pipe_is_load_i  input  1  pipe-stage producer is a load (data not yet valid).
REQ-019 flush_i  input  1  synchronous kill of latched and incoming instruction.
REQ-020 ex_ready_i  input  1  execute accepts ex_* this cycle.
REQ-021 ex_valid_o  output  1  ex_* holds a valid instruction.
REQ-022 ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o  output  DATA_W each  latched fields.
REQ-023 ex_rd_idx_o  output  5;  ex_rd_wb_n_o  output  1;  ex_ctrl_o  output  CTRL_W  latched fields.
REQ-024 stall_cnt_o  output  16  saturating count of load-use stall cycles.

Function
REQ-025 Operand select SHALL be: rsN = (rsN_fwd_sig_i==0) ? rsN_fwd_data_i : rsN_rf_data_i, evaluated in the capture cycle.
REQ-026 hazard SHALL be id_valid_i & pipe_is_load_i & ~pipe_wb_n_i & (pipe_rd_idx_i!=0) & ((rs1_using_i & rs1_idx_i==pipe_rd_idx_i) | (rs2_using_i & rs2_idx_i==pipe_rd_idx_i)).
REQ-027 adv SHALL be ~ex_valid_o | ex_ready_i (output register free or draining).
REQ-028 id_ready_o SHALL be flush_i | (adv & ~hazard), combinational.
REQ-029 On adv & id_valid_i & ~hazard & ~flush_i, all ex_* fields SHALL capture next edge with ex_valid_o=1 (one-cycle latency).
REQ-030 On adv & hazard & ~flush_i, ex_valid_o SHALL become 0 (bubble) and FSM SHALL enter STALL.
REQ-031 On adv & ~id_valid_i & ~flush_i, ex_valid_o SHALL become 0.
REQ-032 On ~adv & ~flush_i, all ex_* outputs SHALL hold unchanged.
REQ-033 FSM states SHALL be RUN and STALL; STALL->RUN when hazard=0 or flush_i=1; STALL holds while hazard=1.
REQ-034 stall_cnt_o SHALL increment by 1 every cycle hazard=1 and flush_i=0, saturating at 16'hFFFF.
REQ-035 flush_i SHALL take priority: next edge ex_valid_o=0, FSM=RUN, upstream instruction discarded, regardless of ex_ready_i or hazard.
REQ-036 When ex_valid_o=0, data fields are don't-care, but ex_rd_wb_n_o SHALL be 1.

Reset
REQ-037 rst_n=0 SHALL asynchronously force ex_valid_o=0, ex_rd_wb_n_o=1, all other ex_* to 0, stall_cnt_o=0, FSM=RUN.
REQ-038 Reset mid-stall SHALL discard the pending instruction; first accept after release follows REQ-029.

Verification
REQ-039 Release reset, id_valid_i=1, pc_i=0x100, rs1_fwd_sig_i=0, rs1_fwd_data_i=0xAA, rs1_rf_data_i=0x55, ex_ready_i=1 -> next cycle ex_valid_o=1, ex_pc_o=0x100, ex_rs1_data_o=0xAA.
REQ-040 pipe_is_load_i=1, pipe_wb_n_i=0, pipe_rd_idx_i=5, rs2_using_i=1, rs2_idx_i=5 for one cycle -> id_ready_o=0, next ex_valid_o=0, stall_cnt_o=1; hazard drops -> instruction captured following cycle.
REQ-041 Same as REQ-040 but pipe_rd_idx_i=0 -> no stall, id_ready_o=1, stall_cnt_o stays 0.
REQ-042 ex_valid_o=1, ex_ready_i=0 for 3 cycles while inputs change -> ex_* stable, id_ready_o=0.
REQ-043 flush_i=1 with ex_ready_i=0 and hazard=1 -> id_ready_o=1, next cycle ex_valid_o=0, FSM=RUN, stall_cnt_o unchanged.
REQ-044 Force 65536 hazard cycles -> stall_cnt_o=16'hFFFF and holds.
